// File: rtl/rtc_bus_sequencer.sv
// Multiplexed-bus sequencer for the external RTC: one transaction engine shared
// between CPU single commands and a periodic register-block scanner.
module rtc_bus_sequencer #(
    parameter int         PHASE_CYC   = 10,
    parameter logic [7:0] SCAN_BASE   = 8'h21,
    parameter int         SCAN_N      = 9,
    parameter int         SCAN_PERIOD = 2_500_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       req_valid,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       done,
    output logic [7:0] rd_data,
    input  logic       scan_en,
    output logic       scan_we,
    output logic [3:0] scan_idx,
    output logic [7:0] scan_data,
    output logic       busy,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    localparam int PH_W  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2
    } state_t;

    state_t            state_q;
    logic [PH_W-1:0]   ph_q;
    logic              launch_q;
    logic              src_cpu_q;
    logic              cmd_wr_q;
    logic [7:0]        cmd_addr_q;
    logic [7:0]        cmd_data_q;
    logic [7:0]        cap_q;

    logic              ad_q, cs_q, rd_q, wr_q, oe_q, busy_q;
    logic [7:0]        bus_out_q;
    logic              req_ready_q, done_q, scan_we_q;
    logic [7:0]        rd_data_q, scan_data_q;
    logic [3:0]        scan_idx_q;

    logic [PER_W-1:0]  per_q, per_d;
    logic              round_q, round_d;
    logic [3:0]        sidx_q, sidx_d;
    logic              trig;
    logic              ph_last;
    logic              scan_done_now;
    logic              arb_slot;

    assign ph_last       = (ph_q == PH_W'(PHASE_CYC - 1));
    assign scan_done_now = (state_q == S_GAP2) && ph_last && !src_cpu_q;
    // Arbitration also happens on the GAP2 exit edge so a grant can coincide with done.
    assign arb_slot      = ((state_q == S_IDLE) && !launch_q) || ((state_q == S_GAP2) && ph_last);

    always_comb begin
        per_d = per_q;
        trig  = 1'b0;
        if (!scan_en) begin
            per_d = '0;
        end else if (per_q == PER_W'(SCAN_PERIOD - 1)) begin
            per_d = '0;
            trig  = 1'b1;
        end else begin
            per_d = per_q + PER_W'(1);
        end
    end

    always_comb begin
        round_d = round_q;
        sidx_d  = sidx_q;
        if (scan_done_now) begin
            sidx_d = sidx_q + 4'd1;
            if (sidx_q == 4'(SCAN_N - 1)) begin
                round_d = 1'b0;
            end
        end
        if (trig && !round_q) begin
            round_d = 1'b1;
            sidx_d  = '0;
        end
        if (!scan_en) begin
            round_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            launch_q    <= 1'b0;
            src_cpu_q   <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cap_q       <= '0;
            ad_q        <= 1'b1;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            bus_out_q   <= '0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            scan_we_q   <= 1'b0;
            rd_data_q   <= '0;
            scan_data_q <= '0;
            scan_idx_q  <= '0;
            per_q       <= '0;
            round_q     <= 1'b0;
            sidx_q      <= '0;
        end else begin
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            scan_we_q   <= 1'b0;
            per_q       <= per_d;
            round_q     <= round_d;
            sidx_q      <= sidx_d;

            if (arb_slot) begin
                if (req_valid) begin
                    launch_q    <= 1'b1;
                    src_cpu_q   <= 1'b1;
                    req_ready_q <= 1'b1;
                    cmd_wr_q    <= req_wr;
                    cmd_addr_q  <= req_addr;
                    cmd_data_q  <= req_data;
                end else if (round_d) begin
                    launch_q    <= 1'b1;
                    src_cpu_q   <= 1'b0;
                    cmd_wr_q    <= 1'b0;
                    cmd_addr_q  <= SCAN_BASE + 8'(sidx_d);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (launch_q) begin
                        launch_q <= 1'b0;
                        // A scan item not yet on the bus is dropped if scanning was disabled.
                        if (src_cpu_q || scan_en) begin
                            state_q   <= S_ADDR;
                            ph_q      <= '0;
                            busy_q    <= 1'b1;
                            ad_q      <= 1'b0;
                            cs_q      <= 1'b0;
                            wr_q      <= 1'b0;
                            rd_q      <= 1'b1;
                            oe_q      <= 1'b1;
                            bus_out_q <= cmd_addr_q;
                        end
                    end
                end
                default: begin
                    if (!ph_last) begin
                        ph_q <= ph_q + PH_W'(1);
                    end else begin
                        ph_q <= '0;
                        case (state_q)
                            S_ADDR: begin
                                state_q <= S_GAP1;
                                ad_q    <= 1'b1;
                                cs_q    <= 1'b1;
                                wr_q    <= 1'b1;
                            end
                            S_GAP1: begin
                                state_q <= S_DATA;
                                cs_q    <= 1'b0;
                                if (cmd_wr_q) begin
                                    wr_q      <= 1'b0;
                                    bus_out_q <= cmd_data_q;
                                end else begin
                                    rd_q <= 1'b0;
                                    oe_q <= 1'b0;
                                end
                            end
                            S_DATA: begin
                                state_q <= S_GAP2;
                                cs_q    <= 1'b1;
                                rd_q    <= 1'b1;
                                wr_q    <= 1'b1;
                                oe_q    <= 1'b0;
                                cap_q   <= bus_in;
                            end
                            default: begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                if (src_cpu_q) begin
                                    done_q <= 1'b1;
                                    if (!cmd_wr_q) begin
                                        rd_data_q <= cap_q;
                                    end
                                end else begin
                                    scan_we_q   <= 1'b1;
                                    scan_idx_q  <= sidx_q;
                                    scan_data_q <= cap_q;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign scan_we   = scan_we_q;
    assign scan_idx  = scan_idx_q;
    assign scan_data = scan_data_q;
    assign busy      = busy_q;
    assign AD        = ad_q;
    assign CS        = cs_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a simple RTC register-file model on the pad.
module tb_rtc_bus_sequencer;

    localparam int PH = 4;
    localparam int TXN = 4 * PH;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req_valid, req_wr;
    logic [7:0] req_addr, req_data;
    logic       req_ready, done;
    logic [7:0] rd_data;
    logic       scan_en;
    logic       scan_we;
    logic [3:0] scan_idx;
    logic [7:0] scan_data;
    logic       busy, AD, CS, RD, WR;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_addr;

    rtc_bus_sequencer #(
        .PHASE_CYC  (PH),
        .SCAN_BASE  (8'h21),
        .SCAN_N     (3),
        .SCAN_PERIOD(100)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .req_valid(req_valid),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .done     (done),
        .rd_data  (rd_data),
        .scan_en  (scan_en),
        .scan_we  (scan_we),
        .scan_idx (scan_idx),
        .scan_data(scan_data),
        .busy     (busy),
        .AD       (AD),
        .CS       (CS),
        .RD       (RD),
        .WR       (WR),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .bus_in   (bus_in)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // RTC model: latch address while AD is low, store write data during the write strobe.
    always @(posedge Clk) begin
        if (!AD) rtc_addr <= bus_out;
        if (!CS && !WR && AD && bus_oe) rtc_mem[rtc_addr] <= bus_out;
    end
    assign bus_in = rtc_mem[rtc_addr];

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cyc_ok(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        logic [4:0] es;
        logic       chk_bo;
        logic [7:0] ebo;
        int         p;
        p      = k / PH;
        chk_bo = 1'b0;
        ebo    = a;
        case (p)
            0: begin es = 5'b00101; chk_bo = 1'b1; end
            1: begin es = 5'b11111; chk_bo = 1'b1; end
            2: begin
                if (wr) begin es = 5'b10101; chk_bo = 1'b1; ebo = d; end
                else    es = 5'b10010;
            end
            default: es = 5'b11110;
        endcase
        return ({AD, CS, RD, WR, bus_oe} == es) && busy && !req_ready && !done && !scan_we &&
               (!chk_bo || bus_out == ebo);
    endfunction

    // Caller is at the negedge of the first ADDR cycle; returns at the last GAP2 cycle.
    // act 1 raises a CPU read of 7F at cycle act_at, act 2 drops scan_en there.
    task automatic body(input string nm, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int act_at, input int act);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int k = 0; k < TXN; k++) begin
            if (k != 0) @(negedge Clk);
            if (!cyc_ok(k, wr, a, d)) begin
                bad++;
                if (first < 0) first = k;
            end
            if (k == act_at && act == 1) begin
                req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h7F; req_data = 8'h00;
            end
            if (k == act_at && act == 2) scan_en = 1'b0;
        end
        chk($sformatf("%s waveform bad cycles (first %0d)", nm, first), bad, 0);
    endtask

    task automatic wait_busy(input int budget, output int n);
        for (n = 1; n <= budget; n++) begin
            @(negedge Clk);
            if (busy) break;
        end
    endtask

    task automatic cpu_txn(input string nm, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd);
        int  t_ready;
        logic got;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        req_valid = 1'b0;
        chk({nm, " req_ready seen"}, 32'(got), 1);
        t_ready = cyc;
        @(negedge Clk);
        body(nm, wr, a, d, -1, 0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (done) begin got = 1'b1; break; end
        end
        chk({nm, " ready-to-done cycles"}, 32'(cyc - t_ready), TXN + 1);
        chk({nm, " idle strobes AD,CS,RD,WR,oe,busy"}, {AD, CS, RD, WR, bus_oe, busy}, 6'b111100);
        if (!wr) chk({nm, " rd_data"}, rd_data, exp_rd);
    endtask

    task automatic scan_done_chk(input string nm, input logic [3:0] idx, input logic [7:0] dat);
        @(negedge Clk);
        chk({nm, " scan_we,done"}, {scan_we, done}, 2'b10);
        chk({nm, " scan_idx"}, scan_idx, idx);
        chk({nm, " scan_data"}, scan_data, dat);
    endtask

    task automatic quiet(input string nm, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (busy || scan_we || done) act++;
        end
        chk({nm, " activity cycles"}, act, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int t_ready;
        int bad;

        vecs[0]  = '{1'b1, 8'h21, 8'h45, 8'h00};
        vecs[1]  = '{1'b1, 8'h22, 8'h37, 8'h00};
        vecs[2]  = '{1'b0, 8'h22, 8'h00, 8'h37};
        vecs[3]  = '{1'b0, 8'h21, 8'h00, 8'h45};
        vecs[4]  = '{1'b1, 8'h7F, 8'hA5, 8'h00};
        vecs[5]  = '{1'b0, 8'h7F, 8'h00, 8'hA5};
        vecs[6]  = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[8]  = '{1'b1, 8'h5A, 8'hC3, 8'h00};
        vecs[9]  = '{1'b0, 8'h5A, 8'h00, 8'hC3};
        vecs[10] = '{1'b1, 8'h21, 8'h10, 8'h00};
        vecs[11] = '{1'b1, 8'h22, 8'h11, 8'h00};
        vecs[12] = '{1'b1, 8'h23, 8'h12, 8'h00};

        Reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; scan_en = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset strobes/oe/busy/pulses",
            {AD, CS, RD, WR, bus_oe, busy, req_ready, done, scan_we}, 9'b1111_0_0000);
        chk("reset bus_out", bus_out, 8'h00);
        chk("reset rd_data", rd_data, 8'h00);
        chk("reset scan_idx", scan_idx, 4'h0);
        chk("reset scan_data", scan_data, 8'h00);
        Reset = 1'b0;
        quiet("post-reset idle", 3);

        for (int i = 0; i < 13; i++) begin
            cpu_txn($sformatf("vec%0d %s %02h", i, vecs[i].wr ? "W" : "R", vecs[i].addr),
                    vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
            @(negedge Clk);
        end

        // Full scan round: 3 reads of 21..23.
        scan_en = 1'b1;
        wait_busy(150, n);
        chk("scan1 start latency", n, 101);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin
                wait_busy(5, n);
                chk($sformatf("scan1 item%0d spacing", i), n, 1);
            end
            body($sformatf("scan1 item%0d", i), 1'b0, 8'h21 + 8'(i), 8'h00, -1, 0);
            scan_done_chk($sformatf("scan1 item%0d", i), 4'(i), 8'h10 + 8'(i));
        end
        quiet("scan1 round end", 20);
        scan_en = 1'b0;
        @(negedge Clk);

        // CPU request raised during item 1 is served between items 1 and 2.
        scan_en = 1'b1;
        wait_busy(150, n);
        chk("scan2 start latency", n, 101);
        body("scan2 item0", 1'b0, 8'h21, 8'h00, -1, 0);
        scan_done_chk("scan2 item0", 4'd0, 8'h10);
        wait_busy(5, n);
        body("scan2 item1", 1'b0, 8'h22, 8'h00, 5, 1);
        scan_done_chk("scan2 item1", 4'd1, 8'h11);
        chk("scan2 cpu granted at item1 end", 32'(req_ready), 1);
        req_valid = 1'b0;
        t_ready = cyc;
        @(negedge Clk);
        body("scan2 cpu R 7F", 1'b0, 8'h7F, 8'h00, -1, 0);
        @(negedge Clk);
        chk("scan2 cpu done,scan_we", {done, scan_we}, 2'b10);
        chk("scan2 cpu ready-to-done", 32'(cyc - t_ready), TXN + 1);
        chk("scan2 cpu rd_data", rd_data, 8'hA5);
        wait_busy(5, n);
        chk("scan2 item2 follows cpu", n, 1);
        body("scan2 item2", 1'b0, 8'h23, 8'h00, -1, 0);
        scan_done_chk("scan2 item2", 4'd2, 8'h12);
        scan_en = 1'b0;
        quiet("scan2 after round", 10);

        // Reset during the DATA phase of a write.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_data = 8'h99;
        wait_busy(10, n);
        req_valid = 1'b0;
        chk("rst-mid started", 32'(busy), 1);
        bad = 0;
        for (int k = 0; k <= 9; k++) begin
            if (k != 0) @(negedge Clk);
            if (!cyc_ok(k, 1'b1, 8'h40, 8'h99)) bad++;
            if (k == 9) Reset = 1'b1;
        end
        chk("rst-mid pre-reset waveform bad cycles", bad, 0);
        @(negedge Clk);
        chk("rst-mid after reset strobes/oe/busy/done",
            {AD, CS, RD, WR, bus_oe, busy, done, req_ready}, 8'b1111_0000);
        Reset = 1'b0;
        quiet("rst-mid no done", 25);
        cpu_txn("post-reset R 22", 1'b0, 8'h22, 8'h00, 8'h11);
        @(negedge Clk);

        // scan_en dropped during item 0; counter restarts on re-enable.
        scan_en = 1'b1;
        wait_busy(150, n);
        chk("scan3 start latency", n, 101);
        body("scan3 item0", 1'b0, 8'h21, 8'h00, 3, 2);
        scan_done_chk("scan3 item0", 4'd0, 8'h10);
        quiet("scan3 cancelled", 60);
        scan_en = 1'b1;
        wait_busy(150, n);
        chk("scan4 restart latency", n, 101);
        body("scan4 item0", 1'b0, 8'h21, 8'h00, 2, 2);
        scan_done_chk("scan4 item0", 4'd0, 8'h10);
        quiet("scan4 cancelled", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequencer and arbiter for the multiplexed address/data bus of the external RTC. Shares a single bus transaction engine between two requesters: the PicoBlaze port logic (single read/write commands) and an autonomous scanner that periodically reads a consecutive block of RTC time registers into the display/register path. It generates all RTC strobes (AD, CS, RD, WR), drives the bidirectional bus enable, and captures read data. It replaces separate read/write strobe generators and their select multiplexer.

## Interface
- PHASE_CYC, 10: clock cycles per bus phase (≥2).
- SCAN_BASE, 8'h21: first RTC address read by the scanner.
- SCAN_N, 9: number of consecutive addresses per scan round (1..16).
- SCAN_PERIOD, 2_500_000: cycles between scan triggers (≥ SCAN_N·4·PHASE_CYC+SCAN_N).
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU command pending; held until req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  8  RTC register address.
- req_data  in  8  write data.
- req_ready  out  1  one-cycle pulse: CPU command accepted.
- done  out  1  one-cycle pulse: CPU transaction finished.
- rd_data  out  8  last CPU read result; valid with done.
- scan_en  in  1  enables periodic scanning.
- scan_we  out  1  one-cycle pulse per scanned register.
- scan_idx  out  4  index 0..SCAN_N-1 of scanned register.
- scan_data  out  8  scanned value; valid with scan_we.
- busy  out  1  transaction engine not in IDLE.
- AD, CS, RD, WR  out  1 each  RTC strobes, active low.
- bus_out  out  8  value for the bidirectional pad.
- bus_oe  out  1  1 = drive pad with bus_out.
- bus_in  in  8  pad input value.

## Operation
- Engine FSM: IDLE → ADDR → GAP1 → DATA → GAP2 → IDLE; each non-IDLE state lasts exactly PHASE_CYC cycles (phase counter 0..PHASE_CYC-1).
- ADDR: AD=0, CS=0, WR=0, bus_oe=1, bus_out=address.
- GAP1: all strobes 1, bus_oe=1, bus_out=address held.
- DATA write: AD=1, CS=0, WR=0, bus_oe=1, bus_out=data. DATA read: AD=1, CS=0, RD=0, bus_oe=0; bus_in sampled on final DATA cycle.
- GAP2: all strobes 1, bus_oe=0.
- Arbitration only in IDLE, evaluated every cycle: CPU request has priority over a pending scan item. Scanner never aborts a transaction; CPU may interleave between scan items of a round.
- Accept: req_ready pulses in the IDLE cycle of grant; address/data/direction latched then; engine enters ADDR next cycle.
- Completion on GAP2 → IDLE: CPU read loads rd_data; CPU read or write pulses done. Scan read pulses scan_we with scan_idx, scan_data; scan index increments; round ends after index SCAN_N-1.
- Scanner: period counter runs 0..SCAN_PERIOD-1 while scan_en=1, cleared while scan_en=0. Wrap sets scan_pending; round starts at index 0, addresses SCAN_BASE+idx (8-bit wrap). Trigger during an active round is dropped. scan_en deasserted mid-round: current transaction completes, remaining items cancelled.
- Reset (any time, including mid-transaction): FSM→IDLE; AD=CS=RD=WR=1; bus_oe=0; bus_out=0; req_ready=done=scan_we=0; rd_data=0; scan_idx=0; scan_data=0; busy=0; scan_pending and period counter cleared.

## Timing
- All outputs registered; strobes change only at phase boundaries.
- Transaction length: 4·PHASE_CYC cycles from first ADDR cycle to last GAP2 cycle; done/scan_we asserted the following cycle (IDLE), total 4·PHASE_CYC+1 from req_ready to done.
- Back-to-back: next grant possible in the same IDLE cycle as done, so minimum spacing between ADDR starts is 4·PHASE_CYC+1.
- busy=1 from first ADDR cycle through last GAP2 cycle.
- Simultaneous req_valid and scan trigger in IDLE: CPU granted; scan pending retained.

## Test plan
- Reset, PHASE_CYC=4: CPU write addr 8'h21 data 8'h45 → AD low 4 cycles with bus_out=21, WR low in both ADDR and DATA, bus_out=45 in DATA, done exactly 17 cycles after req_ready.
- CPU read addr 8'h22, bus_in=8'h37 during DATA → RD low 4 cycles, bus_oe=0, rd_data=37 with done, WR stays 1.
- Scan, SCAN_N=3, SCAN_PERIOD=100, bus_in=idx+8'h10 → scan_we three times, scan_idx 0,1,2, scan_data 10,11,12, addresses 21,22,23.
- CPU req_valid raised during scan item 1 → CPU transaction runs after item 1, item 2 follows; no strobe glitches; req_ready waits until IDLE.
- Reset asserted mid-DATA of a write → next cycle all strobes 1, bus_oe=0, busy=0, no done pulse; fresh read then completes normally.
- scan_en dropped during item 0 → item 0 completes with scan_we, no further scan_we; counter restarts from 0 on re-enable.
